stack_pointer_ctrl: RTL
=======================

// Module: stack_pointer_ctrl
// PURPOSE
//  Parametrised, bounds-checked stack pointer for the CPU datapath; successor to the fixed 16-bit up/down SP.
//  Tracks the stack pointer, a load-defined base (empty point) and the current depth.
//  Supplies push-write and pop-read addresses to memory.
//  Blocks push past MAX_DEPTH and pop below the base; raises sticky overflow/underflow flags.
//  Supports grow-down or grow-up stacks and a configurable step size.
// PARAMETERS
//  AW        16       address/pointer width in bits
//  STEP      1        pointer change per push/pop; must satisfy 1 <= STEP < 2^AW
//  GROW_DOWN 1        1: push decrements sp; 0: push increments sp
//  MAX_DEPTH 256      maximum number of stacked entries; must be >= 1
//  RST_SP    16'h0100 sp and base value after reset (AW bits wide)
//  DW (localparam) = $clog2(MAX_DEPTH+1), the width of depth
// PORTS
//  clk       in   1   clock; all state updates on the rising edge
//  reset     in   1   asynchronous, active-low reset (0 = reset asserted)
//  enable    in   1   0 = hold all pointer state (load/push/pop ignored)
//  load      in   1   load sp and base from in_addr; depth cleared
//  in_addr   in   AW  new stack base for load
//  push      in   1   push one entry
//  pop       in   1   pop one entry
//  clr_err   in   1   clear sticky ovf/unf; not gated by enable
//  sp        out  AW  next-free-slot pointer; also the push write address
//  top_addr  out  AW  address of the top entry (pop read address): GROW_DOWN ? sp+STEP : sp-STEP
//  depth     out  DW  entries currently stacked
//  empty     out  1   depth == 0
//  full      out  1   depth == MAX_DEPTH
//  ovf       out  1   sticky: push attempted while full
//  unf       out  1   sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (reset=0, asynchronous, no clock edge needed):
//    sp = base = RST_SP; depth = 0; empty = 1; full = 0; ovf = unf = 0.
//  Output timing:
//    sp, depth, ovf and unf are registered; updates appear one cycle after the command edge.
//    top_addr, empty and full are combinational from the registers.
//  Command priority per edge: enable=0 (hold) > load > push/pop.
//  load: sp <= in_addr; base <= in_addr; depth <= 0. Flags are unaffected.
//  Convention: "advance" = sp - STEP when GROW_DOWN=1, sp + STEP when GROW_DOWN=0; "retreat" is the opposite direction.
//  push only:
//    not full: sp <= advance; depth += 1.
//    full: sp and depth unchanged; ovf <= 1.
//  pop only:
//    not empty: sp <= retreat; depth -= 1.
//    empty: sp and depth unchanged; unf <= 1.
//  push and pop in the same cycle = replace top:
//    sp and depth unchanged; no flag set, even when empty or full.
//  Address arithmetic is modulo 2^AW; wrap-around is legal and not an error. Only depth bounds the stack.
//  clr_err=1: ovf <= 0 and unf <= 0 on that edge.
//    If a new error occurs on the same edge, the set wins for that flag.
//  base is internal; invariant: sp == base advanced by depth*STEP (mod 2^AW).
// TESTING
//  Reset behaviour:
//    Assert reset=0 mid-run without a clock edge -> sp=0x0100, depth=0, empty=1, ovf=unf=0 immediately.
//  Load, push, pop (defaults):
//    load in_addr=0x00F0, then 3 pushes -> sp=0x00ED, depth=3, top_addr=0x00EE.
//    3 pops -> sp=0x00F0, empty=1.
//  Overflow (MAX_DEPTH=4):
//    load 0x00F0, 5 pushes -> sp=0x00EC, depth=4, full=1, ovf=1 (stays set).
//    clr_err=1 -> ovf=0.
//  Underflow and hold:
//    pop while empty -> unf=1, sp unchanged.
//    enable=0 with load=1, in_addr=0xAAAA, push=1 -> no state change for 5 cycles.
//  Simultaneous commands:
//    at depth 2, push=pop=1 -> sp and depth unchanged, no flags.
//    at depth 0, push=pop=1 -> unf stays 0.
//  Grow-up with wrap (GROW_DOWN=0, STEP=2):
//    load 0xFFFE, push -> sp=0x0000, depth=1, top_addr=0xFFFE.
//    pop -> sp=0xFFFE.

Source files
------------

// File: rtl/stack_pointer_ctrl.sv
// Bounds-checked stack pointer: tracks sp, base and depth, and provides push/pop
// addresses. Sticky overflow/underflow flags record rejected commands.
module stack_pointer_ctrl #(
  parameter int unsigned    AW        = 16,
  parameter int unsigned    STEP      = 1,
  parameter bit             GROW_DOWN = 1'b1,
  parameter int unsigned    MAX_DEPTH = 256,
  parameter logic [AW-1:0]  RST_SP    = AW'(16'h0100),
  localparam int unsigned   DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          load,
  input  logic [AW-1:0] in_addr,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_err,
  output logic [AW-1:0] sp,
  output logic [AW-1:0] top_addr,
  output logic [DW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam logic [AW-1:0] STEP_V = AW'(STEP);
  localparam logic [DW-1:0] MAX_V  = DW'(MAX_DEPTH);

  logic [AW-1:0] sp_q, sp_d;
  logic [AW-1:0] base_q, base_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] sp_adv, sp_ret;
  logic          empty_w, full_w;

  // Pointer moves in the push direction (advance) and the pop direction (retreat).
  always_comb begin
    sp_adv = GROW_DOWN ? (sp_q - STEP_V) : (sp_q + STEP_V);
    sp_ret = GROW_DOWN ? (sp_q + STEP_V) : (sp_q - STEP_V);
  end

  assign empty_w = (depth_q == '0);
  assign full_w  = (depth_q == MAX_V);

  // Next-state: hold > load > push/pop; a simultaneous push+pop replaces the top in place.
  always_comb begin
    sp_d    = sp_q;
    base_d  = base_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (enable) begin
      if (load) begin
        sp_d    = in_addr;
        base_d  = in_addr;
        depth_d = '0;
      end else if (push && !pop) begin
        if (full_w) begin
          ovf_d = 1'b1;
        end else begin
          sp_d    = sp_adv;
          depth_d = depth_q + DW'(1);
        end
      end else if (pop && !push) begin
        if (empty_w) begin
          unf_d = 1'b1;
        end else begin
          sp_d    = sp_ret;
          depth_d = depth_q - DW'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q    <= RST_SP;
      base_q  <= RST_SP;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      base_q  <= base_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign sp       = sp_q;
  assign top_addr = sp_ret;
  assign depth    = depth_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule
